// File: rtl/pixel_region_scan_if.sv
// Bundle of configuration inputs and scan outputs between the readout control
// (master) and the pixel region scanner (slave).
interface pixel_region_scan_if #(
  parameter int ROW_LENGTH    = 32,
  parameter int COLUMN_LENGTH = 16,
  parameter int DWELL_WIDTH   = 8,
  parameter int ROW_AW        = $clog2(ROW_LENGTH),
  parameter int COL_AW        = $clog2(COLUMN_LENGTH)
);
  logic                     start_i;
  logic                     speak_i;
  logic [1:0]               mode_i;
  logic                     single_i;
  logic [ROW_AW-1:0]        rowStart_i;
  logic [ROW_AW-1:0]        rowEnd_i;
  logic [COL_AW-1:0]        colStart_i;
  logic [COL_AW-1:0]        colEnd_i;
  logic [DWELL_WIDTH-1:0]   dwell_i;
  logic                     busy_o;
  logic                     marker_o;
  logic                     frameDone_o;
  logic [ROW_LENGTH-1:0]    rowSel_o;
  logic [COLUMN_LENGTH-1:0] columnSel_o;
  logic [ROW_AW-1:0]        rowAddr_o;
  logic [COL_AW-1:0]        colAddr_o;

  modport master (
    output start_i, speak_i, mode_i, single_i, rowStart_i, rowEnd_i,
           colStart_i, colEnd_i, dwell_i,
    input  busy_o, marker_o, frameDone_o, rowSel_o, columnSel_o,
           rowAddr_o, colAddr_o
  );

  modport slave (
    input  start_i, speak_i, mode_i, single_i, rowStart_i, rowEnd_i,
           colStart_i, colEnd_i, dwell_i,
    output busy_o, marker_o, frameDone_o, rowSel_o, columnSel_o,
           rowAddr_o, colAddr_o
  );
endinterface

// File: rtl/pixel_region_scan.sv
// Pixel matrix scanner: walks a region of interest in raster or serpentine
// order with per-pixel dwell, driving one-hot row/column selects.
module pixel_region_scan #(
  parameter int ROW_LENGTH    = 32,
  parameter int COLUMN_LENGTH = 16,
  parameter int DWELL_WIDTH   = 8,
  parameter int ROW_AW        = $clog2(ROW_LENGTH),
  parameter int COL_AW        = $clog2(COLUMN_LENGTH)
) (
  input  logic          clock_i,
  input  logic          reset_i,
  pixel_region_scan_if.slave bus
);
  localparam logic [ROW_AW-1:0] ROW_MAX = ROW_AW'(ROW_LENGTH - 1);
  localparam logic [COL_AW-1:0] COL_MAX = COL_AW'(COLUMN_LENGTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, PAUSE = 2'd2} state_t;

  state_t                 state_reg, state_next;
  logic                   start_q_reg;
  logic                   serp_reg, serp_next;
  logic                   single_reg, single_next;
  logic [ROW_AW-1:0]      rs_reg, rs_next, re_reg, re_next, row_reg, row_next;
  logic [COL_AW-1:0]      cs_reg, cs_next, ce_reg, ce_next, col_reg, col_next;
  logic [DWELL_WIDTH-1:0] dwell_reg, dwell_next, cnt_reg, cnt_next;
  logic                   marker_reg, marker_next, done_reg, done_next;

  logic                   start_edge, use_roi;
  logic [ROW_AW-1:0]      rs_in, re_in, row_off;
  logic [COL_AW-1:0]      cs_in, ce_in, term_col;
  logic                   rev_row, at_term, last_pixel, busy;

  assign start_edge = bus.start_i & ~start_q_reg;
  assign use_roi    = (bus.mode_i == 2'b01) || (bus.mode_i == 2'b10);

  // Bounds as they will be latched on a start edge, already clamped.
  always_comb begin
    rs_in = '0;
    re_in = ROW_MAX;
    cs_in = '0;
    ce_in = COL_MAX;
    if (use_roi) begin
      rs_in = (32'(bus.rowStart_i) >= ROW_LENGTH)    ? ROW_MAX : bus.rowStart_i;
      re_in = (32'(bus.rowEnd_i)   >= ROW_LENGTH)    ? ROW_MAX : bus.rowEnd_i;
      cs_in = (32'(bus.colStart_i) >= COLUMN_LENGTH) ? COL_MAX : bus.colStart_i;
      ce_in = (32'(bus.colEnd_i)   >= COLUMN_LENGTH) ? COL_MAX : bus.colEnd_i;
      if (re_in < rs_in) re_in = rs_in;
      if (ce_in < cs_in) ce_in = cs_in;
    end
  end

  // Odd rows relative to the ROI start run backwards in serpentine order.
  assign row_off    = row_reg - rs_reg;
  assign rev_row    = serp_reg & row_off[0];
  assign term_col   = rev_row ? cs_reg : ce_reg;
  assign at_term    = (col_reg == term_col);
  assign last_pixel = at_term && (row_reg == re_reg);

  always_comb begin
    state_next  = state_reg;
    serp_next   = serp_reg;
    single_next = single_reg;
    rs_next     = rs_reg;
    re_next     = re_reg;
    cs_next     = cs_reg;
    ce_next     = ce_reg;
    dwell_next  = dwell_reg;
    cnt_next    = cnt_reg;
    row_next    = row_reg;
    col_next    = col_reg;
    marker_next = 1'b0;
    done_next   = 1'b0;
    if (start_edge) begin
      serp_next   = (bus.mode_i == 2'b10);
      single_next = bus.single_i;
      rs_next     = rs_in;
      re_next     = re_in;
      cs_next     = cs_in;
      ce_next     = ce_in;
      dwell_next  = bus.dwell_i;
      cnt_next    = bus.dwell_i;
      row_next    = rs_in;
      col_next    = cs_in;
      marker_next = 1'b1;
      state_next  = bus.speak_i ? SCAN : PAUSE;
    end else begin
      case (state_reg)
        IDLE: state_next = IDLE;
        SCAN, PAUSE: begin
          if (!bus.speak_i) begin
            state_next = PAUSE;
          end else begin
            state_next = SCAN;
            if (cnt_reg != '0) begin
              cnt_next = cnt_reg - 1'b1;
            end else begin
              cnt_next = dwell_reg;
              if (last_pixel) begin
                done_next = 1'b1;
                if (single_reg) begin
                  state_next = IDLE;
                end else begin
                  row_next    = rs_reg;
                  col_next    = cs_reg;
                  marker_next = 1'b1;
                end
              end else if (!at_term) begin
                col_next = rev_row ? col_reg - 1'b1 : col_reg + 1'b1;
              end else begin
                row_next = row_reg + 1'b1;
                col_next = (serp_reg & ~row_off[0]) ? ce_reg : cs_reg;
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg   <= IDLE;
      start_q_reg <= 1'b0;
      serp_reg    <= 1'b0;
      single_reg  <= 1'b0;
      rs_reg      <= '0;
      re_reg      <= '0;
      cs_reg      <= '0;
      ce_reg      <= '0;
      dwell_reg   <= '0;
      cnt_reg     <= '0;
      row_reg     <= '0;
      col_reg     <= '0;
      marker_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      start_q_reg <= bus.start_i;
      serp_reg    <= serp_next;
      single_reg  <= single_next;
      rs_reg      <= rs_next;
      re_reg      <= re_next;
      cs_reg      <= cs_next;
      ce_reg      <= ce_next;
      dwell_reg   <= dwell_next;
      cnt_reg     <= cnt_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      marker_reg  <= marker_next;
      done_reg    <= done_next;
    end
  end

  assign busy = (state_reg != IDLE);

  logic [ROW_LENGTH-1:0]    row_sel;
  logic [COLUMN_LENGTH-1:0] col_sel;

  for (genvar gi = 0; gi < ROW_LENGTH; gi++) begin : g_row_sel
    assign row_sel[gi] = busy && (row_reg == ROW_AW'(gi));
  end

  for (genvar gi = 0; gi < COLUMN_LENGTH; gi++) begin : g_col_sel
    assign col_sel[gi] = busy && (col_reg == COL_AW'(gi));
  end

  assign bus.busy_o      = busy;
  assign bus.marker_o    = marker_reg;
  assign bus.frameDone_o = done_reg;
  assign bus.rowSel_o    = row_sel;
  assign bus.columnSel_o = col_sel;
  assign bus.rowAddr_o   = row_reg;
  assign bus.colAddr_o   = col_reg;
endmodule
